buf_tag_lookup: RTL and testbench
=================================

# buf_tag_lookup

Tag lookup and allocation controller for the four-entry buffer pool; sits directly upstream of the LRU replacement finder. It accepts tag requests, compares them against four stored buffer tags, and reports hit/miss with a buffer number. On a miss it allocates a buffer: a free one if available, otherwise the LRU victim. It then runs a fill handshake and sends each reference or allocation to the LRU finder as a one-cycle update.

## Interface
- TAG_W, 8, request/stored tag width (1..32)
- clk  in  1  rising-edge clock, only clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  lookup request present
- req_tag  in  TAG_W  tag to look up
- req_ready  out  1  high only in IDLE with no flush pending
- resp_valid  out  1  response held until resp_ready
- resp_ready  in  1  consumer accepts response
- resp_hit  out  1  1 = hit, 0 = miss (filled)
- resp_buf  out  2  buffer number holding the tag
- fill_req_valid  out  1  fill request to buffer memory, held until fill_done
- fill_req_buf  out  2  buffer being filled
- fill_req_tag  out  TAG_W  tag being filled
- fill_done  in  1  one-cycle fill completion pulse
- flush  in  1  one-cycle pulse, invalidates all entries
- buf_num_replc  in  2  LRU victim from the LRU finder
- ref_buf_valid  out  1  one-cycle LRU update strobe
- ref_buf_numbr  out  2  buffer referenced/allocated
- new_buf_req  out  1  qualifies strobe: 1 = replacement of a full pool, 0 = hit or free-slot allocation

## Operation
- States: IDLE, LOOKUP, FILL, RESP.
- IDLE:
  - req_valid & req_ready: register req_tag, go to LOOKUP.
  - If a flush is pending: clear all valid bits, stay in IDLE. req_ready is 0 in that cycle.
- LOOKUP: compare the registered tag with the 4 entries whose valid bit is set.
  - Hit at index i: ref_buf_valid=1, ref_buf_numbr=i, new_buf_req=0. resp_hit=1, resp_buf=i. Go to RESP.
  - Miss with a free entry: allocate the lowest-index entry with valid=0. Go to FILL.
  - Miss with all valid: allocate buf_num_replc, sampled in this cycle. Go to FILL.
  - Multiple matches cannot occur by construction. If they do, the lowest index wins.
- FILL:
  - fill_req_valid=1, with fill_req_buf and fill_req_tag stable.
  - On fill_done: write the tag, set the valid bit, and pulse ref_buf_valid with ref_buf_numbr=allocated buffer. new_buf_req=1 iff the pool was full at LOOKUP. resp_hit=0. Go to RESP.
- RESP: resp_valid=1. When resp_ready, go to IDLE.
- flush outside IDLE is latched as pending and applied on the next IDLE cycle, before any new request is accepted.
- The in-flight entry is written on fill_done even if a flush is pending; the pending flush then clears it.
- fill_done outside FILL is ignored.

## Timing
- Reset values:
  - State IDLE; all valid bits 0; tags 0.
  - req_ready=1.
  - resp_valid, resp_hit, resp_buf, fill_req_valid, fill_req_buf, fill_req_tag, ref_buf_valid, ref_buf_numbr, new_buf_req all 0.
  - Flush-pending cleared.
- rst mid-operation aborts any fill: fill_req_valid drops the next cycle and the entry is not written.
- Hit latency: request accepted at edge T; LOOKUP during cycle T+1; resp_valid from T+2.
- Miss latency: fill_req_valid from T+2; resp_valid the cycle after fill_done is sampled.
- ref_buf_valid is exactly one cycle wide per request: the LOOKUP cycle on a hit, the fill_done cycle on a miss.
- All outputs are registered except req_ready, which is decoded from state and flush-pending.

## Configuration
- BUF_LOOKUP_STATS_EN defined: adds outputs hit_cnt and miss_cnt, 16 bits each.
  - They count at resp_valid & resp_ready.
  - They saturate at 16'hFFFF, reset to 0, and are not cleared by flush.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

## Structure
- Shared package buf_pkg: NUM_BUF=4, BUF_IDX_W=2, and the state enum (IDLE, LOOKUP, FILL, RESP).
- One sub-module, buf_tag_match: combinational 4-way tag compare. Outputs are a hit flag, the lowest hit index, an all-valid flag and the lowest free index.

## Test plan
- After reset, request tag 8'h11 → miss; fill_req_buf=0; on fill_done: ref_buf_valid, ref_buf_numbr=0, new_buf_req=0; resp_hit=0, resp_buf=0.
- Fill tags 11, 22, 33, 44, then request 22 → resp_hit=1, resp_buf=1 at T+2; ref_buf_valid with ref_buf_numbr=1, new_buf_req=0; no fill_req_valid.
- Pool full, buf_num_replc=2, request 8'h55 → fill_req_buf=2; on fill_done new_buf_req=1, ref_buf_numbr=2; a later request for 33 → miss.
- flush pulse during FILL → request completes normally; req_ready=0 for one IDLE cycle; a following request for 11 → miss, allocated to buffer 0.
- rst asserted in FILL → next cycle fill_req_valid=0, req_ready=1; a request for the aborted tag → miss.
- With BUF_LOOKUP_STATS_EN: 3 hits and 2 misses → hit_cnt=3, miss_cnt=2. Hold resp_ready=0 for 5 cycles → resp_valid and resp_buf stable, and counters increment only once.

Source files
------------

// File: rtl/buf_pkg.sv
// Shared constants and FSM state encoding for the four-entry buffer pool.
package buf_pkg;
    localparam int NUM_BUF   = 4;
    localparam int BUF_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FILL,
        RESP
    } state_t;
endpackage

// File: rtl/buf_tag_match.sv
// Combinational 4-way tag compare: hit flag and lowest hit index, plus
// all-valid flag and lowest free index for allocation.
module buf_tag_match
    import buf_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic [TAG_W-1:0]                tag_i,
    input  logic [NUM_BUF-1:0][TAG_W-1:0]   tags_i,
    input  logic [NUM_BUF-1:0]              valid_i,
    output logic                            hit_o,
    output logic [BUF_IDX_W-1:0]            hit_idx_o,
    output logic                            all_valid_o,
    output logic [BUF_IDX_W-1:0]            free_idx_o
);

    logic [NUM_BUF-1:0] match;

    generate
        for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_cmp
            assign match[gi] = valid_i[gi] && (tags_i[gi] == tag_i);
        end
    endgenerate

    // Scan from the top down so the lowest index wins on duplicates.
    always_comb begin
        hit_idx_o  = '0;
        free_idx_o = '0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (match[i])    hit_idx_o  = BUF_IDX_W'(i);
            if (!valid_i[i]) free_idx_o = BUF_IDX_W'(i);
        end
    end

    assign hit_o       = |match;
    assign all_valid_o = &valid_i;

endmodule

// File: rtl/buf_tag_lookup.sv
// Tag lookup / allocation controller for the buffer pool, feeding LRU updates.
// Optional hit/miss counters are enabled with BUF_LOOKUP_STATS_EN.
module buf_tag_lookup
    import buf_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [TAG_W-1:0]     req_tag,
    output logic                 req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_hit,
    output logic [1:0]           resp_buf,
    output logic                 fill_req_valid,
    output logic [1:0]           fill_req_buf,
    output logic [TAG_W-1:0]     fill_req_tag,
    input  logic                 fill_done,
    input  logic                 flush,
    input  logic [1:0]           buf_num_replc,
    output logic                 ref_buf_valid,
    output logic [1:0]           ref_buf_numbr,
    output logic                 new_buf_req
`ifdef BUF_LOOKUP_STATS_EN
    ,
    output logic [15:0]          hit_cnt,
    output logic [15:0]          miss_cnt
`endif
);

    state_t                         state_q;
    logic [NUM_BUF-1:0]             valid_q;
    logic [NUM_BUF-1:0][TAG_W-1:0]  tags_q;
    logic [TAG_W-1:0]               tag_q;
    logic [BUF_IDX_W-1:0]           alloc_q;
    logic                           full_q;
    logic                           flush_pend_q, flush_pend_d;

    logic                           resp_valid_q, resp_hit_q;
    logic [BUF_IDX_W-1:0]           resp_buf_q;
    logic                           fill_req_valid_q;
    logic [BUF_IDX_W-1:0]           fill_req_buf_q;
    logic [TAG_W-1:0]               fill_req_tag_q;
    logic                           ref_buf_valid_q, new_buf_req_q;
    logic [BUF_IDX_W-1:0]           ref_buf_numbr_q;

    logic                           m_hit, m_all_valid;
    logic [BUF_IDX_W-1:0]           m_hit_idx, m_free_idx, alloc_sel;

    buf_tag_match #(.TAG_W(TAG_W)) u_match (
        .tag_i       (tag_q),
        .tags_i      (tags_q),
        .valid_i     (valid_q),
        .hit_o       (m_hit),
        .hit_idx_o   (m_hit_idx),
        .all_valid_o (m_all_valid),
        .free_idx_o  (m_free_idx)
    );

    assign alloc_sel    = m_all_valid ? buf_num_replc : m_free_idx;
    // A pending flush is consumed by the first IDLE cycle that sees it.
    assign flush_pend_d = flush || (flush_pend_q && (state_q != IDLE));
    assign req_ready    = (state_q == IDLE) && !flush_pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            valid_q          <= '0;
            tags_q           <= '0;
            tag_q            <= '0;
            alloc_q          <= '0;
            full_q           <= 1'b0;
            flush_pend_q     <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_hit_q       <= 1'b0;
            resp_buf_q       <= '0;
            fill_req_valid_q <= 1'b0;
            fill_req_buf_q   <= '0;
            fill_req_tag_q   <= '0;
            ref_buf_valid_q  <= 1'b0;
            ref_buf_numbr_q  <= '0;
            new_buf_req_q    <= 1'b0;
        end else begin
            ref_buf_valid_q <= 1'b0;
            flush_pend_q    <= flush_pend_d;
            case (state_q)
                IDLE: begin
                    if (flush_pend_q) begin
                        valid_q <= '0;
                    end else if (req_valid) begin
                        tag_q   <= req_tag;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (m_hit) begin
                        ref_buf_valid_q <= 1'b1;
                        ref_buf_numbr_q <= m_hit_idx;
                        new_buf_req_q   <= 1'b0;
                        resp_hit_q      <= 1'b1;
                        resp_buf_q      <= m_hit_idx;
                        resp_valid_q    <= 1'b1;
                        state_q         <= RESP;
                    end else begin
                        alloc_q          <= alloc_sel;
                        full_q           <= m_all_valid;
                        fill_req_valid_q <= 1'b1;
                        fill_req_buf_q   <= alloc_sel;
                        fill_req_tag_q   <= tag_q;
                        state_q          <= FILL;
                    end
                end
                FILL: begin
                    if (fill_done) begin
                        tags_q[alloc_q]  <= tag_q;
                        valid_q[alloc_q] <= 1'b1;
                        fill_req_valid_q <= 1'b0;
                        ref_buf_valid_q  <= 1'b1;
                        ref_buf_numbr_q  <= alloc_q;
                        new_buf_req_q    <= full_q;
                        resp_hit_q       <= 1'b0;
                        resp_buf_q       <= alloc_q;
                        resp_valid_q     <= 1'b1;
                        state_q          <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_hit       = resp_hit_q;
    assign resp_buf       = resp_buf_q;
    assign fill_req_valid = fill_req_valid_q;
    assign fill_req_buf   = fill_req_buf_q;
    assign fill_req_tag   = fill_req_tag_q;
    assign ref_buf_valid  = ref_buf_valid_q;
    assign ref_buf_numbr  = ref_buf_numbr_q;
    assign new_buf_req    = new_buf_req_q;

`ifdef BUF_LOOKUP_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (resp_valid_q && resp_ready) begin
            if (resp_hit_q) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_buf_tag_lookup.sv
// Directed, table-driven bench for buf_tag_lookup: one line per transaction.
module tb_buf_tag_lookup;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [7:0] req_tag;
    logic       req_ready;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_hit;
    logic [1:0] resp_buf;
    logic       fill_req_valid;
    logic [1:0] fill_req_buf;
    logic [7:0] fill_req_tag;
    logic       fill_done;
    logic       flush;
    logic [1:0] buf_num_replc;
    logic       ref_buf_valid;
    logic [1:0] ref_buf_numbr;
    logic       new_buf_req;
`ifdef BUF_LOOKUP_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    always #5 clk = ~clk;

    buf_tag_lookup #(.TAG_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_tag        (req_tag),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_hit       (resp_hit),
        .resp_buf       (resp_buf),
        .fill_req_valid (fill_req_valid),
        .fill_req_buf   (fill_req_buf),
        .fill_req_tag   (fill_req_tag),
        .fill_done      (fill_done),
        .flush          (flush),
        .buf_num_replc  (buf_num_replc),
        .ref_buf_valid  (ref_buf_valid),
        .ref_buf_numbr  (ref_buf_numbr),
        .new_buf_req    (new_buf_req)
`ifdef BUF_LOOKUP_STATS_EN
        ,
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
`endif
    );

    typedef struct {
        logic [7:0] tag;
        logic [1:0] replc;
        logic       exp_hit;
        logic [1:0] exp_buf;
        logic       exp_new;
        logic       do_flush;
        int         hold;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_stats();
`ifdef BUF_LOOKUP_STATS_EN
        check("hit_cnt", 32'(hit_cnt), 32'(exp_hits));
        check("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
`endif
    endtask

    task automatic wait_ready();
        int t = 0;
        while (req_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (req_ready !== 1'b1) check("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    // Full request/response transaction; called at a negedge.
    task automatic txn(input vec_t v);
        logic [1:0] held_buf;
        wait_ready();
        buf_num_replc = v.replc;
        req_tag       = v.tag;
        req_valid     = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("lookup_no_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        if (v.exp_hit) begin
            check("hit_no_fill", 32'(fill_req_valid), 32'd0);
        end else begin
            check("fill_valid", 32'(fill_req_valid), 32'd1);
            check("fill_buf", 32'(fill_req_buf), 32'(v.exp_buf));
            check("fill_tag", 32'(fill_req_tag), 32'(v.tag));
            check("fill_no_resp", 32'(resp_valid), 32'd0);
            @(negedge clk);
            if (v.do_flush) flush = 1'b1;
            check("fill_held", 32'(fill_req_valid), 32'd1);
            check("fill_no_ref", 32'(ref_buf_valid), 32'd0);
            @(negedge clk);
            flush     = 1'b0;
            fill_done = 1'b1;
            @(negedge clk);
            fill_done = 1'b0;
            check("fill_dropped", 32'(fill_req_valid), 32'd0);
        end
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_hit", 32'(resp_hit), 32'(v.exp_hit));
        check("resp_buf", 32'(resp_buf), 32'(v.exp_buf));
        check("ref_valid", 32'(ref_buf_valid), 32'd1);
        check("ref_numbr", 32'(ref_buf_numbr), 32'(v.exp_buf));
        check("new_buf_req", 32'(new_buf_req), 32'(v.exp_new));
        held_buf = resp_buf;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_buf", 32'(resp_buf), 32'(held_buf));
            check("hold_ref_low", 32'(ref_buf_valid), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        if (v.exp_hit) exp_hits++; else exp_miss++;
        check("resp_done", 32'(resp_valid), 32'd0);
        check("ref_one_cycle", 32'(ref_buf_valid), 32'd0);
        check_stats();
        if (v.do_flush) begin
            check("flush_ready_low", 32'(req_ready), 32'd0);
            @(negedge clk);
            check("flush_ready_back", 32'(req_ready), 32'd1);
        end
        $display("txn tag=%02h hit=%0b buf=%0d new=%0b flush=%0b hold=%0d",
                 v.tag, v.exp_hit, v.exp_buf, v.exp_new, v.do_flush, v.hold);
    endtask

    function automatic vec_t mk(input logic [7:0] tag, input logic [1:0] replc,
                                input logic hit, input logic [1:0] b,
                                input logic nw, input logic fl, input int hold);
        vec_t v;
        v.tag = tag; v.replc = replc; v.exp_hit = hit; v.exp_buf = b;
        v.exp_new = nw; v.do_flush = fl; v.hold = hold;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(8'h11, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 0);
        vecs[1]  = mk(8'h22, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0, 0);
        vecs[2]  = mk(8'h33, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0, 0);
        vecs[3]  = mk(8'h44, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0, 0);
        vecs[4]  = mk(8'h22, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0, 0);
        vecs[5]  = mk(8'h55, 2'd2, 1'b0, 2'd2, 1'b1, 1'b0, 0);
        vecs[6]  = mk(8'h33, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 0);
        vecs[7]  = mk(8'h55, 2'd3, 1'b1, 2'd2, 1'b0, 1'b0, 0);
        vecs[8]  = mk(8'h44, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0, 0);
        vecs[9]  = mk(8'h66, 2'd1, 1'b0, 2'd1, 1'b1, 1'b1, 0);
        vecs[10] = mk(8'h11, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 3);
        vecs[11] = mk(8'h11, 2'd2, 1'b1, 2'd0, 1'b0, 1'b0, 5);

        rst = 1'b1; req_valid = 1'b0; req_tag = '0; resp_ready = 1'b0;
        fill_done = 1'b0; flush = 1'b0; buf_num_replc = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_hit", 32'(resp_hit), 32'd0);
        check("rst_resp_buf", 32'(resp_buf), 32'd0);
        check("rst_fill_valid", 32'(fill_req_valid), 32'd0);
        check("rst_fill_buf", 32'(fill_req_buf), 32'd0);
        check("rst_fill_tag", 32'(fill_req_tag), 32'd0);
        check("rst_ref_valid", 32'(ref_buf_valid), 32'd0);
        check("rst_ref_numbr", 32'(ref_buf_numbr), 32'd0);
        check("rst_new_buf", 32'(new_buf_req), 32'd0);
        check_stats();

        // Stray fill_done in IDLE must have no effect.
        fill_done = 1'b1;
        @(negedge clk);
        fill_done = 1'b0;
        check("stray_done_resp", 32'(resp_valid), 32'd0);
        check("stray_done_ref", 32'(ref_buf_valid), 32'd0);
        check("stray_done_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 12; i++) txn(vecs[i]);

        // Reset during FILL aborts the fill without writing the entry.
        wait_ready();
        req_tag = 8'h77; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_fill_valid", 32'(fill_req_valid), 32'd1);
        check("abort_fill_buf", 32'(fill_req_buf), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
        check("abort_fill_drop", 32'(fill_req_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        $display("txn rst during fill of tag=77");
        txn(mk(8'h77, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
